gpu_opcode_fetch: RTL and testbench
===================================

# gpu_opcode_fetch

Upstream feeder for the GPU core array. It synchronizes the external GPU byte strobe into the system clock domain and captures one 8-bit byte per strobe rising edge. Each pair of bytes is assembled into a 16-bit opcode and buffered in a small FIFO. Opcodes are issued to the core array as a one-cycle `execute` pulse, gated by the array's `core_ready`.

## Interface
- `FIFO_DEPTH`, default 4: opcode FIFO entries; power of two, minimum 2.
- `clk`  in  1  system clock (same clock as the VGA block).
- `rst`  in  1  synchronous, active-high reset.
- `byte_in`  in  8  opcode byte, `{ui_in[3:0], uio_in[3:0]}`; must be stable from 1 cycle before the strobe rises until 3 cycles after.
- `byte_strobe`  in  1  raw GPU strobe pin; asynchronous to `clk`.
- `flush`  in  1  synchronous clear of the FIFO and byte phase.
- `core_ready`  in  1  core array can accept an opcode this cycle.
- `opcode`  out  16  opcode presented with `execute`: first byte in `[15:8]`, second byte in `[7:0]`.
- `execute`  out  1  one-cycle issue pulse.
- `fifo_full`  out  1  count == `FIFO_DEPTH`.
- `fifo_empty`  out  1  count == 0.
- `overflow`  out  1  sticky; an opcode was dropped.
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO count.

## Operation
- **Strobe synchronizer:** two flops, `s1` then `s2`, plus a `prev` flop. `edge = s2 & ~prev`. Falling edges are ignored.
- **Byte assembler:** one phase bit plus an 8-bit `hi` register.
  - On `edge` with phase=0: `hi <= byte_in`, phase <= 1.
  - On `edge` with phase=1: push `{hi, byte_in}`, phase <= 0.
- **FIFO:**
  - Read and write pointers wrap modulo `FIFO_DEPTH`; the count is kept explicitly.
  - No fall-through: a word pushed at edge P is poppable at edge P+1 at the earliest.
- **Issue:**
  - At each edge, if `!fifo_empty && core_ready`: `opcode <= head`, `execute <= 1`, pop.
  - Otherwise `execute <= 0`; `opcode` holds its last value.
  - Back-to-back issue is allowed: one opcode per cycle while `core_ready` stays high.
- **Push onto a full FIFO with no pop in the same cycle:**
  - The word is dropped and `overflow <= 1`.
  - Phase still returns to 0.
  - `overflow` clears only on `rst`; `flush` does not clear it.
- **Simultaneous push and pop:**
  - When full: accepted, count unchanged, no overflow.
  - When empty: the pop does not occur (empty is evaluated before the push); the count becomes 1.
- **`flush`:**
  - Resets the pointers, count and phase, and forces `execute <= 0`.
  - A push in the same cycle is discarded.
  - `flush` overrides `edge`.
- **`rst`:**
  - Clears the synchronizer flops, phase, `hi`, pointers, count, `opcode` (0x0000), `execute`, and `overflow`.
  - Mid-opcode reset discards the pending first byte.
- **Reset values of outputs:** `opcode`=0, `execute`=0, `fifo_full`=0, `fifo_empty`=1, `overflow`=0, `level`=0.
- **Strobe held high through reset:** because `prev` resets to 0 and `s1`/`s2` then resample high, it produces exactly one edge after reset release. This is accepted behaviour.

## Timing
- Strobe high first sampled into `s1` at edge N; `s2`=1 after N+1; `edge` is active in the cycle between N+1 and N+2.
- The byte is captured, or the opcode pushed, at edge N+2.
- With `core_ready`=1 and an otherwise empty FIFO:
  - `execute`=1 and `opcode` valid during the cycle after N+3.
  - Strobe-to-issue latency is 4 edges.
- Minimum strobe period is 4 `clk` cycles: 2 high, 2 low.
- `fifo_full`, `fifo_empty` and `level` are registered or derived from the registered count, and are valid the cycle after the push or pop.
- `execute` is never high for two cycles from one opcode.

## Test plan
- **Reset:** hold `rst` 2 cycles → `execute`=0, `opcode`=0x0000, `fifo_empty`=1, `level`=0, `overflow`=0.
- **Single opcode:** bytes 0xA5 then 0x3C on strobes, `core_ready`=1 → exactly one `execute` pulse with `opcode`=0xA53C, 4 edges after the second strobe's first sample.
- **Backpressure and fill:** `core_ready`=0; push 5 opcodes 0x0101..0x0505 with depth 4 →
  - `level`=4 and `fifo_full`=1; `overflow`=1 after the 5th.
  - Raise `core_ready` → 0x0101..0x0404 issued on 4 consecutive cycles.
- **Full with simultaneous pop:** FIFO full and `core_ready`=1, push 0x7777 in the same cycle as a pop → `level` stays 4, `overflow` stays 0, and 0x7777 is issued last.
- **Mid-opcode reset and flush:**
  - Send 0x11, pulse `rst`, then send 0x22 and 0x33 → single issue of 0x2233.
  - Repeat the scenario with `flush` in place of `rst` → same result, and `overflow` is preserved.
- **Strobe stuck high through reset:** hold `byte_strobe`=1 across reset release → exactly one byte captured (phase=1); no `execute` until a second strobe edge.

Source files
------------

// File: rtl/gpu_opcode_fetch_if.sv
// Issue bus from the opcode fetcher to the core array: one opcode per execute pulse.
// The core array raises core_ready when it can accept an opcode that cycle.
interface gpu_opcode_fetch_if;
  logic [15:0] opcode;
  logic        execute;
  logic        core_ready;

  modport master (output opcode, output execute, input core_ready);
  modport slave  (input opcode, input execute, output core_ready);
endinterface

// File: rtl/gpu_opcode_fetch.sv
// Strobe-synchronised byte pairs -> 16-bit opcodes -> FIFO -> one-cycle execute pulses.
// Strobe-to-issue is 4 edges; core_ready low holds opcodes, a push onto a full FIFO is dropped.
module gpu_opcode_fetch #(
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         byte_in_i,
  input  logic               byte_strobe_i,
  input  logic               flush_i,
  gpu_opcode_fetch_if.master issue_if,
  output logic               fifo_full_o,
  output logic               fifo_empty_o,
  output logic               overflow_o,
  output logic [LVL_W-1:0]   level_o
);

  logic             s1_q, s2_q, prev_q;
  logic             phase_q;
  logic [7:0]       hi_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] count_q, count_d;
  logic [15:0]      opcode_q;
  logic             execute_q;
  logic             overflow_q;
  logic [15:0]      mem_q [FIFO_DEPTH];

  logic strobe_edge, full, empty, push_req, push, pop, drop;

  always_comb begin
    strobe_edge = s2_q & ~prev_q;
    full        = (count_q == LVL_W'(FIFO_DEPTH));
    empty       = (count_q == '0);
    // Emptiness is judged on the registered count, so a word never falls through.
    pop         = ~empty & issue_if.core_ready & ~flush_i;
    push_req    = strobe_edge & phase_q & ~flush_i;
    push        = push_req & (~full | pop);
    drop        = push_req & full & ~pop;
    count_d     = count_q;
    if (push && !pop) begin
      count_d = count_q + LVL_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {hi_q, byte_in_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      prev_q     <= 1'b0;
      phase_q    <= 1'b0;
      hi_q       <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      opcode_q   <= 16'h0000;
      execute_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      s1_q   <= byte_strobe_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      if (flush_i) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
        phase_q   <= 1'b0;
        execute_q <= 1'b0;
      end else begin
        if (strobe_edge) begin
          if (!phase_q) begin
            hi_q    <= byte_in_i;
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
          end
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
          opcode_q <= mem_q[rd_ptr_q];
        end
        if (drop) begin
          overflow_q <= 1'b1;
        end
        execute_q <= pop;
        count_q   <= count_d;
      end
    end
  end

  assign issue_if.opcode  = opcode_q;
  assign issue_if.execute = execute_q;
  assign fifo_full_o      = full;
  assign fifo_empty_o     = empty;
  assign overflow_o       = overflow_q;
  assign level_o          = count_q;

endmodule

// File: tb/tb_gpu_opcode_fetch.sv
// Directed stimulus for gpu_opcode_fetch with a queue scoreboard checked by a negedge monitor.
module tb_gpu_opcode_fetch;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_strobe;
  logic       flush;
  logic       fifo_full, fifo_empty, overflow;
  logic [2:0] level;

  gpu_opcode_fetch_if ifc ();

  gpu_opcode_fetch #(.FIFO_DEPTH(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .byte_in_i     (byte_in),
    .byte_strobe_i (byte_strobe),
    .flush_i       (flush),
    .issue_if      (ifc),
    .fifo_full_o   (fifo_full),
    .fifo_empty_o  (fifo_empty),
    .overflow_o    (overflow),
    .level_o       (level)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int strobe_cyc = 0;
  int exec_cyc   = 0;
  logic [15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every execute pulse must match the oldest expected opcode.
  always @(negedge clk) begin
    if (ifc.execute === 1'b1) begin
      exec_cyc = cyc;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_execute: opcode 0x%04h issued, none expected", ifc.opcode);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (ifc.opcode !== e) begin
          mismatched++;
          $display("FAIL issued_opcode: got 0x%04h expected 0x%04h", ifc.opcode, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in = b;
    tick();
    byte_strobe = 1'b1;
    strobe_cyc  = cyc;
    repeat (2) tick();
    byte_strobe = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send_op(input logic [15:0] op, input bit expect_issue);
    if (expect_issue) exp_q.push_back(op);
    send_byte(op[15:8]);
    send_byte(op[7:0]);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; byte_in = 8'h00; byte_strobe = 1'b0; flush = 1'b0; ifc.core_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_execute",  ifc.execute, 0);
    check("rst_opcode",   ifc.opcode, 16'h0000);
    check("rst_empty",    fifo_empty, 1);
    check("rst_full",     fifo_full, 0);
    check("rst_level",    level, 0);
    check("rst_overflow", overflow, 0);

    // Single opcode and strobe-to-issue latency.
    ifc.core_ready = 1'b1;
    send_op(16'hA53C, 1);
    wait_drain("single_drain");
    check("single_latency", exec_cyc - strobe_cyc, 4);

    // Fill under backpressure; fifth opcode dropped.
    ifc.core_ready = 1'b0;
    send_op(16'h0101, 1);
    send_op(16'h0202, 1);
    send_op(16'h0303, 1);
    send_op(16'h0404, 1);
    check("fill_level", level, 4);
    check("fill_full", fifo_full, 1);
    check("fill_no_overflow", overflow, 0);
    send_op(16'h0505, 0);
    check("ovf_level", level, 4);
    check("ovf_flag", overflow, 1);
    ifc.core_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_execute", ifc.execute, 1);
      @(posedge clk);
    end
    @(negedge clk);
    check("b2b_end", ifc.execute, 0);
    #1;
    wait_drain("fill_drain");

    // Mid-opcode flush keeps overflow.
    send_byte(8'h11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    send_op(16'h4455, 1);
    wait_drain("flush_drain");
    check("flush_keeps_overflow", overflow, 1);

    // Mid-opcode reset.
    send_byte(8'h11);
    pulse_rst();
    check("rst_clears_overflow", overflow, 0);
    send_op(16'h2233, 1);
    wait_drain("rst_drain");

    // Full FIFO with push and pop on the same edge.
    ifc.core_ready = 1'b0;
    send_op(16'h1111, 1);
    send_op(16'h2222, 1);
    send_op(16'h3333, 1);
    send_op(16'h4444, 1);
    exp_q.push_back(16'h7777);
    send_byte(8'h77);
    byte_in = 8'h77;
    tick();
    byte_strobe = 1'b1;
    repeat (2) tick();
    byte_strobe = 1'b0;
    ifc.core_ready = 1'b1;
    @(negedge clk);
    check("pp_pre_full", fifo_full, 1);
    @(negedge clk);
    check("pp_level", level, 4);
    check("pp_overflow", overflow, 0);
    #1;
    wait_drain("pp_drain");

    // Strobe stuck high across reset release yields exactly one captured byte.
    byte_strobe = 1'b1;
    byte_in = 8'h5C;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (8) tick();
    check("stuck_level", level, 0);
    check("stuck_no_exec", ifc.execute, 0);
    byte_strobe = 1'b0;
    repeat (3) tick();
    exp_q.push_back(16'h5C9A);
    send_byte(8'h9A);
    wait_drain("stuck_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
